// File: rtl/spi_slave_counter_rx_if.sv
// SPI link between the counter master and the display-board receiver.
// Mode 0: sclk idles low, ss is active low.
interface spi_slave_counter_rx_if;
  logic sclk;
  logic mosi;
  logic ss;
  logic miso;

  modport master (output sclk, output mosi, output ss, input miso);
  modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_slave_counter_rx.sv
// SPI mode-0 slave: rebuilds the 14-bit counter from a 2-byte frame,
// pulses o_valid/o_frame_err, and echoes the last accepted value on miso.
module spi_slave_counter_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CHECK_PAD   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  spi_slave_counter_rx_if.slave        spi,
  output logic [13:0]                  o_data,
  output logic                         o_valid,
  output logic                         o_frame_err
);
  localparam int unsigned DW   = 14;
  localparam int unsigned CW   = 5;
  localparam int unsigned WARM = SYNC_STAGES + 1;
  localparam int unsigned WW   = $clog2(WARM + 1);

  localparam logic [CW-1:0] CNT_BYTE  = CW'(8);
  localparam logic [CW-1:0] CNT_FRAME = CW'(16);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RX_HIGH = 3'd1;
  localparam logic [2:0] RX_LOW  = 3'd2;
  localparam logic [2:0] OVERRUN = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_d1_q, ss_d1_q;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, in_frame, armed, pad_ok;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [15:0]   tx_shift_q, tx_shift_d;
  logic [7:0]    hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d, err_q, err_d, miso_q, miso_d, pend_q, pend_d;
  logic [WW-1:0] warm_q, warm_d;

  // Input synchronizers plus one-cycle delayed copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_d1_q   <= 1'b0;
      ss_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
      sclk_d1_q   <= sclk_s;
      ss_d1_q     <= ss_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];

  // The ss chain resets high, so a pin already low at release would look like
  // a fall; ignore ss edges until the chain holds real samples.
  assign armed     = (warm_q == WW'(WARM));
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign ss_fall   = ~ss_s & ss_d1_q & armed;
  assign ss_rise   = ss_s & ~ss_d1_q;
  assign in_frame  = ~ss_s & ((state_q == RX_HIGH) | (state_q == RX_LOW) | (state_q == OVERRUN));
  assign pad_ok    = !CHECK_PAD || (hi_q[7:6] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      miso_q     <= 1'b0;
      pend_q     <= 1'b0;
      warm_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      miso_q     <= miso_d;
      pend_q     <= pend_d;
      warm_q     <= warm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    pend_d     = pend_q;
    warm_d     = armed ? warm_q : warm_q + WW'(1);
    miso_d     = ss_s ? 1'b0 : tx_shift_q[15];

    if (in_frame && sclk_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CW'(1);
    end
    if (in_frame && sclk_fall) tx_shift_d = {tx_shift_q[14:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (ss_fall || pend_q) begin
          pend_d     = 1'b0;
          bit_cnt_d  = '0;
          tx_shift_d = {2'b00, data_q};
          state_d    = RX_HIGH;
        end
      end
      RX_HIGH: begin
        if (ss_rise)                  state_d = COMMIT;
        else if (bit_cnt_q > CNT_FRAME) state_d = OVERRUN;
        else if (bit_cnt_q == CNT_BYTE) begin
          hi_d    = rx_shift_q;
          state_d = RX_LOW;
        end
      end
      RX_LOW: begin
        if (ss_rise)                     state_d = COMMIT;
        else if (bit_cnt_q > CNT_FRAME)  state_d = OVERRUN;
        else if (bit_cnt_q == CNT_FRAME) lo_d = rx_shift_q;
      end
      OVERRUN: begin
        if (ss_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (ss_fall) pend_d = 1'b1;
        // A bare ss toggle (no clocks) is neither accepted nor an error
        if ((bit_cnt_q == CNT_FRAME) && pad_ok) begin
          valid_d = 1'b1;
          data_d  = {hi_q[5:0], lo_q};
        end else if (bit_cnt_q != '0) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign spi.miso    = miso_q;
endmodule

// File: doc/spi_slave_counter_rx.md
Name: spi_slave_counter_rx

Overview:
- SPI slave receiver on the display board, directly downstream of the counter master's SPI link.
- Samples sclk/mosi/ss from the master and reassembles the 2-byte frame into the 14-bit counter value: high byte {2'b00, cnt[13:8]}, then low byte cnt[7:0].
- Presents the value with a one-cycle valid pulse to the FND display stage.
- Echoes the previously accepted value on miso.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each synchronizer for sclk, mosi and ss (minimum 2).
- CHECK_PAD, 1, when 1, a high byte with bits[7:6] != 2'b00 is a frame error.

Ports:
- clk  input  1  system clock; sclk must be at most clk/8.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master, mode 0 (idle low).
- mosi  input  1  serial data from master, MSB first.
- ss  input  1  slave select, active low, frames one 2-byte transaction.
- miso  output  1  serial echo data to master.
- o_data  output  14  last accepted counter value.
- o_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_frame_err=0, miso=0, FSM=IDLE, all shift registers, counters and synchronizers cleared (ss synchronizer resets to 1).
- Synchronization: sclk, mosi and ss each pass through SYNC_STAGES flip-flops. Edge detection uses the synchronized signal and its one-cycle delayed copy.
- Sampling:
  - Synchronized sclk rising edge while ss_s=0 shifts mosi_s into rx_shift[7:0] (MSB first) and increments bit_cnt[4:0] (saturates at 31).
  - Synchronized sclk falling edge while ss_s=0 shifts tx_shift left; miso = tx_shift[15] registered.
- FSM states: IDLE, RX_HIGH, RX_LOW, OVERRUN, COMMIT.
  - IDLE: on ss_s falling edge, clear bit_cnt and load tx_shift = {2'b00, o_data[13:8], o_data[7:0]}; go to RX_HIGH.
  - RX_HIGH: when bit_cnt reaches 8, latch hi_reg = rx_shift; go to RX_LOW.
  - RX_LOW: when bit_cnt reaches 16, latch lo_reg = rx_shift; stay until ss_s rising edge, then go to COMMIT.
  - Any state: a 17th sclk rising edge while ss_s=0 moves to OVERRUN.
  - OVERRUN: stay until ss_s rising edge.
  - COMMIT: lasts one cycle, then IDLE.
- Commit rule on ss_s rising edge:
  - Bit count exactly 16, and (CHECK_PAD=0 or hi_reg[7:6]=0): o_data = {hi_reg[5:0], lo_reg} and o_valid=1 for one cycle (cycle after ss_s rise is detected).
  - Otherwise o_frame_err=1 for one cycle and o_data is unchanged.
  - Bit count 0 (ss toggled with no clocks): return to IDLE, no pulse.
- Boundary conditions:
  - ss rises mid-byte (bit_cnt 1-7 or 9-15): frame error.
  - ss rises after exactly 8 bits: frame error.
  - sclk edges while ss_s=1: ignored; shift registers and bit_cnt hold.
  - o_valid and o_frame_err are mutually exclusive and never asserted in the same cycle.
  - Back-to-back frames: a new ss fall during COMMIT is registered and handled in IDLE on the next cycle; no frame is lost if ss stays high for at least 2 clk after the synchronizer.
  - Async reset mid-frame: everything returns to reset values immediately, and the partial frame is discarded. After reset release, the FSM waits for a fresh ss falling edge; an ss that is already low is not treated as a frame start.
- Latency: o_valid asserts SYNC_STAGES+2 clk cycles after the raw ss rising edge.

Test Plan:
- Frame 0x27 then 0x0F at sclk=clk/10, ss framed -> o_valid one pulse, o_data=14'd9999 (0x270F), o_frame_err=0.
- Two consecutive frames 0x00,0x05 then 0x3F,0xFF -> two o_valid pulses; o_data=5, then 16383. During the second frame miso shifts out 0x00,0x05.
- ss deasserted after 11 bits of 0x12,0x34 -> o_frame_err pulse, no o_valid, o_data keeps its prior value (e.g. 5).
- High byte 0xC1, low 0x00 with CHECK_PAD=1 -> o_frame_err; same stimulus with CHECK_PAD=0 -> o_valid, o_data=0x0100.
- Frame of 24 bits (0x01,0x02,0x03) -> OVERRUN path, o_frame_err at ss rise, o_data unchanged. Next valid frame 0x00,0x07 -> o_data=7.
- Reset pulsed after 5 bits of a frame, ss held low, then ss released and a clean 0x01,0x00 frame sent -> no pulse from the aborted frame, then o_valid with o_data=256.
